// File: rtl/kvs_pkg.sv
// rtl/kvs_pkg.sv - shared stream widths and arbiter state encoding
package kvs_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_USER_W = 64;

    localparam logic ARB_ST_IDLE   = 1'b0;
    localparam logic ARB_ST_LOCKED = 1'b1;

    typedef enum logic {
        ST_IDLE   = ARB_ST_IDLE,
        ST_LOCKED = ARB_ST_LOCKED
    } arb_state_t;

endpackage

// File: rtl/kvs_tx_arbiter_if.sv
// rtl/kvs_tx_arbiter_if.sv - source-side and sink-side stream bundle of the tx arbiter
interface kvs_tx_arbiter_if #(
    parameter int NR_PORTS = 2,
    parameter int DATA_W   = kvs_pkg::AXIS_DATA_W
);
    import kvs_pkg::*;

    localparam int KEEP_W = DATA_W / 8;

    logic [NR_PORTS*DATA_W-1:0]      s_tdata;
    logic [NR_PORTS*KEEP_W-1:0]      s_tkeep;
    logic [NR_PORTS*AXIS_USER_W-1:0] s_tuser;
    logic [NR_PORTS-1:0]             s_tlast;
    logic [NR_PORTS-1:0]             s_tvalid;
    logic [NR_PORTS-1:0]             s_tready;

    logic [DATA_W-1:0]               m_tdata;
    logic [KEEP_W-1:0]               m_tkeep;
    logic [AXIS_USER_W-1:0]          m_tuser;
    logic                            m_tlast;
    logic                            m_tvalid;
    logic                            m_tready;

    modport master (
        output s_tdata, s_tkeep, s_tuser, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid
    );

    modport slave (
        input  s_tdata, s_tkeep, s_tuser, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid
    );

endinterface

// File: rtl/kvs_tx_arbiter_rr_pick.sv
// rtl/kvs_tx_arbiter_rr_pick.sv - combinational round-robin picker
// First requester at or after the pointer, searching cyclically.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!w_found && i_req[(int'(i_ptr) + off) % N]) begin
                o_grant[(int'(i_ptr) + off) % N] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

    assign o_valid = w_found;

endmodule

// File: rtl/kvs_tx_arbiter.sv
// rtl/kvs_tx_arbiter.sv - packet-locked round-robin merge of N streams
// One arbitration cycle per packet, single registered output stage.
module kvs_tx_arbiter
    import kvs_pkg::*;
#(
    parameter  int NR_PORTS = 2,
    parameter  int DATA_W   = AXIS_DATA_W,
    localparam int GW       = $clog2(NR_PORTS),
    localparam int KEEP_W   = DATA_W / 8
) (
    input  logic                 clk_390,
    input  logic                 sys_rst,
    kvs_tx_arbiter_if.slave      bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [31:0]          pkt_cnt
);

    arb_state_t             r_state;
    logic [GW-1:0]          r_rr_ptr;
    logic [GW-1:0]          r_grant_id;
    logic [31:0]            r_pkt_cnt;
    logic [DATA_W-1:0]      r_m_tdata;
    logic [KEEP_W-1:0]      r_m_tkeep;
    logic [AXIS_USER_W-1:0] r_m_tuser;
    logic                   r_m_tlast;
    logic                   r_m_tvalid;

    logic [NR_PORTS-1:0]    w_pick_oh;
    logic                   w_pick_vld;
    logic [GW-1:0]          w_pick_idx;
    logic [NR_PORTS-1:0]    w_s_tready;
    logic                   w_out_free;
    logic                   w_accept;
    logic                   w_sel_last;

    rr_pick #(.N(NR_PORTS), .PW(GW)) u_rr_pick (
        .i_req   (bus.s_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (w_pick_oh[i]) w_pick_idx = GW'(i);
        end
    end

    // Output stage can take a beat when empty or being drained this cycle.
    assign w_out_free = !r_m_tvalid || bus.m_tready;
    assign w_accept   = (r_state == ST_LOCKED) && w_out_free && bus.s_tvalid[r_grant_id];
    assign w_sel_last = bus.s_tlast[r_grant_id];

    always_comb begin
        w_s_tready = '0;
        if (r_state == ST_LOCKED) w_s_tready[r_grant_id] = w_out_free;
    end

    always_ff @(posedge clk_390 or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_pkt_cnt  <= '0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            if (r_m_tvalid && bus.m_tready && r_m_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;

            if (w_accept) begin
                r_m_tdata  <= bus.s_tdata[int'(r_grant_id)*DATA_W +: DATA_W];
                r_m_tkeep  <= bus.s_tkeep[int'(r_grant_id)*KEEP_W +: KEEP_W];
                r_m_tuser  <= bus.s_tuser[int'(r_grant_id)*AXIS_USER_W +: AXIS_USER_W];
                r_m_tlast  <= w_sel_last;
                r_m_tvalid <= 1'b1;
            end else if (bus.m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant_id <= w_pick_idx;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && w_sel_last) begin
                        r_rr_ptr <= GW'((int'(r_grant_id) + 1) % NR_PORTS);
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_tready = w_s_tready;
    assign bus.m_tdata  = r_m_tdata;
    assign bus.m_tkeep  = r_m_tkeep;
    assign bus.m_tuser  = r_m_tuser;
    assign bus.m_tlast  = r_m_tlast;
    assign bus.m_tvalid = r_m_tvalid;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state == ST_LOCKED);
    assign pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_kvs_tx_arbiter.sv
// tb/tb_kvs_tx_arbiter.sv - scoreboard bench for kvs_tx_arbiter
module tb_kvs_tx_arbiter;
    import kvs_pkg::*;

    localparam int NP = 2;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int GW = $clog2(NP);

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [63:0]   user;
        logic          last;
        int            gap;
    } beat_t;

    logic          clk_390 = 1'b0;
    logic          sys_rst = 1'b1;
    logic [GW-1:0] grant_id;
    logic          busy;
    logic [31:0]   pkt_cnt;

    always #5 clk_390 = ~clk_390;

    kvs_tx_arbiter_if #(.NR_PORTS(NP), .DATA_W(DW)) bus ();

    kvs_tx_arbiter #(.NR_PORTS(NP), .DATA_W(DW)) dut (
        .clk_390  (clk_390),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    beat_t src_q[NP][$];
    beat_t exp_q[$];
    logic  tr_q[$];
    logic  acc[NP];
    int    checks = 0;
    int    errors = 0;

    // Source and sink driver: updates inputs 1 time unit after each rising edge.
    initial begin
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tuser  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk_390);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                bus.s_tvalid[p] = 1'b0;
                if (src_q[p].size() > 0) begin
                    if (src_q[p][0].gap > 0) begin
                        src_q[p][0].gap = src_q[p][0].gap - 1;
                    end else begin
                        bus.s_tvalid[p]            = 1'b1;
                        bus.s_tdata[p*DW +: DW]    = src_q[p][0].data;
                        bus.s_tkeep[p*KW +: KW]    = src_q[p][0].keep;
                        bus.s_tuser[p*64 +: 64]    = src_q[p][0].user;
                        bus.s_tlast[p]             = src_q[p][0].last;
                    end
                end
            end
            bus.m_tready = (tr_q.size() > 0) ? tr_q.pop_front() : 1'b1;
        end
    end

    always @(negedge clk_390) begin
        for (int p = 0; p < NP; p++) acc[p] = bus.s_tvalid[p] & bus.s_tready[p];
    end

    beat_t mon_e;
    beat_t prev;
    logic  prev_stall = 1'b0;

    // Output monitor: scoreboard pop on every accepted beat, hold check on stalls.
    always @(negedge clk_390) begin
        if (sys_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev.data || bus.m_tkeep !== prev.keep ||
                    bus.m_tuser !== prev.user || bus.m_tlast !== prev.last) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", bus.m_tvalid, bus.m_tdata, prev.data);
                end
            end
            if (bus.m_tvalid && bus.m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got d=%h exp none", bus.m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.m_tdata !== mon_e.data || bus.m_tkeep !== mon_e.keep ||
                        bus.m_tuser !== mon_e.user || bus.m_tlast !== mon_e.last) begin
                        errors++;
                        $display("FAIL beat got d=%h k=%h u=%h l=%b exp d=%h k=%h u=%h l=%b",
                                 bus.m_tdata, bus.m_tkeep, bus.m_tuser, bus.m_tlast,
                                 mon_e.data, mon_e.keep, mon_e.user, mon_e.last);
                    end
                end
            end
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev.data  = bus.m_tdata;
            prev.keep  = bus.m_tkeep;
            prev.user  = bus.m_tuser;
            prev.last  = bus.m_tlast;
        end
    end

    task automatic push_pkt(input int port, input int n, input logic [DW-1:0] base,
                            input int gap_idx, input int gap_len);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base * 64'(i + 1);
            b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
            b.user = {$urandom, $urandom};
            b.last = (i == n - 1);
            b.gap  = (i == gap_idx) ? gap_len : 0;
            src_q[port].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(output int left);
        int n = 0;
        while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0 || bus.m_tvalid) && n < 300) begin
            @(negedge clk_390);
            n++;
        end
        left = exp_q.size();
        if (n >= 300 && left == 0) left = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_390);
        checks++;
        if ({grant_id, busy, bus.s_tready, bus.m_tvalid, bus.m_tlast} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got g=%0d b=%b r=%b v=%b l=%b exp all 0",
                     grant_id, busy, bus.s_tready, bus.m_tvalid, bus.m_tlast);
        end
        checks++;
        if ({bus.m_tdata, bus.m_tkeep, bus.m_tuser, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data got d=%h k=%h u=%h c=%0d exp 0", bus.m_tdata, bus.m_tkeep, bus.m_tuser, pkt_cnt);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_single();
        int first = -1, nv = 0, last_i = -1, left;
        @(negedge clk_390);
        push_pkt(0, 3, 64'h11, -1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_390);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b0 || bus.s_tready !== 2'b00) begin
                    errors++;
                    $display("FAIL single_arb got busy=%b rdy=%b exp busy=0 rdy=00", busy, bus.s_tready);
                end
            end
            if (i == 1) begin
                checks++;
                if (busy !== 1'b1 || bus.s_tready !== 2'b01 || grant_id !== 1'b0) begin
                    errors++;
                    $display("FAIL single_lock got busy=%b rdy=%b g=%0d exp 1 01 0", busy, bus.s_tready, grant_id);
                end
            end
            if (bus.m_tvalid) begin
                if (first < 0) first = i;
                nv++;
                if (bus.m_tlast) last_i = i;
            end
        end
        checks++;
        if (first !== 2 || nv !== 3 || last_i !== 4) begin
            errors++;
            $display("FAIL single_timing got first=%0d n=%0d last=%0d exp 2 3 4", first, nv, last_i);
        end
        wait_drain(left);
        checks++;
        if (left !== 0 || pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_cnt got left=%0d cnt=%0d exp 0 1", left, pkt_cnt);
        end
    endtask

    task automatic test_rr();
        logic exp_busy[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int left;
        @(negedge clk_390);
        sys_rst = 1'b1;
        @(negedge clk_390);
        sys_rst = 1'b0;
        push_pkt(0, 2, 64'hA0, -1, 0);
        push_pkt(1, 2, 64'hB0, -1, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_390);
            checks++;
            if (busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL rr_busy[%0d] got %b exp %b", i, busy, exp_busy[i]);
            end
            if (i == 3) begin
                checks++;
                if (bus.s_tready !== 2'b00) begin
                    errors++;
                    $display("FAIL rr_gap_rdy got %b exp 00", bus.s_tready);
                end
            end
            if (i == 1 || i == 4) begin
                checks++;
                if (grant_id !== GW'(i == 4)) begin
                    errors++;
                    $display("FAIL rr_grant[%0d] got %0d exp %0d", i, grant_id, (i == 4));
                end
            end
        end
        wait_drain(left);
        checks++;
        if (left !== 0 || pkt_cnt !== 32'd2) begin
            errors++;
            $display("FAIL rr_cnt got left=%0d cnt=%0d exp 0 2", left, pkt_cnt);
        end
    endtask

    task automatic test_rr_wrap();
        int left;
        @(negedge clk_390);
        push_pkt(0, 1, 64'hC0, -1, 0);
        push_pkt(1, 3, 64'hD0, -1, 0);
        wait_drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL rr_wrap got left=%0d exp 0", left);
        end
    endtask

    task automatic test_stall();
        int nb = 0, left;
        logic [31:0] c0 = pkt_cnt;
        @(negedge clk_390);
        push_pkt(0, 4, 64'h5500, -1, 0);
        tr_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_390);
            if (bus.m_tvalid && bus.m_tready) nb++;
            if (i == 3) begin
                checks++;
                if (bus.m_tvalid !== 1'b1 || bus.s_tready !== 2'b00) begin
                    errors++;
                    $display("FAIL stall_rdy got v=%b rdy=%b exp 1 00", bus.m_tvalid, bus.s_tready);
                end
            end
        end
        checks++;
        if (nb !== 4) begin
            errors++;
            $display("FAIL stall_beats got %0d exp 4", nb);
        end
        wait_drain(left);
        checks++;
        if (left !== 0 || pkt_cnt !== c0 + 32'd1) begin
            errors++;
            $display("FAIL stall_cnt got left=%0d cnt=%0d exp 0 %0d", left, pkt_cnt, c0 + 32'd1);
        end
    endtask

    task automatic test_gap();
        int lock1 = 0, bad = 0, left;
        @(negedge clk_390);
        push_pkt(1, 4, 64'h7700, 2, 5);
        push_pkt(0, 2, 64'h6600, -1, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_390);
            if (busy && grant_id == 1'b1) begin
                lock1++;
                if (bus.s_tready[0]) bad++;
            end
        end
        checks++;
        if (lock1 !== 9 || bad !== 0) begin
            errors++;
            $display("FAIL gap_lock got cycles=%0d p0rdy=%0d exp 9 0", lock1, bad);
        end
        wait_drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL gap_drain got left=%0d exp 0", left);
        end
    endtask

    task automatic test_reset_mid();
        int left;
        @(negedge clk_390);
        push_pkt(0, 4, 64'h4400, -1, 0);
        repeat (3) @(negedge clk_390);
        #2;
        sys_rst = 1'b1;
        src_q[0].delete();
        exp_q.delete();
        tr_q.delete();
        @(negedge clk_390);
        checks++;
        if ({grant_id, busy, bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.m_tkeep, bus.m_tuser, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid got g=%0d b=%b r=%b v=%b d=%h c=%0d exp all 0",
                     grant_id, busy, bus.s_tready, bus.m_tvalid, bus.m_tdata, pkt_cnt);
        end
        @(negedge clk_390);
        sys_rst = 1'b0;
        push_pkt(1, 2, 64'h9900, -1, 0);
        wait_drain(left);
        checks++;
        if (left !== 0 || pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rst_after got left=%0d cnt=%0d exp 0 1", left, pkt_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        int left;
        @(negedge clk_390);
        force dut.r_pkt_cnt = 32'hFFFF_FFFF;
        @(negedge clk_390);
        release dut.r_pkt_cnt;
        #1;
        checks++;
        if (pkt_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preset got %h exp ffffffff", pkt_cnt);
        end
        @(negedge clk_390);
        push_pkt(0, 1, 64'hEE, -1, 0);
        wait_drain(left);
        checks++;
        if (left !== 0 || pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL wrap_cnt got left=%0d cnt=%h exp 0 0", left, pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_rr_wrap();
        test_stall();
        test_gap();
        test_reset_mid();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kvs_tx_arbiter.md
KVS_TX_ARBITER -- requirements
Module: kvs_tx_arbiter

Interface
- REQ-001 SHALL have parameter NR_PORTS, default 2, number of AXI-Stream sources merged (2..4).
- REQ-002 SHALL have parameter DATA_W, default 64, tdata width; tkeep width is DATA_W/8, tuser width is 64.
- REQ-003 SHALL have port clk_390, input, 1, the single clock for all logic.
- REQ-004 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have ports s_tdata / s_tkeep / s_tuser / s_tlast / s_tvalid, all inputs, each the per-port width times NR_PORTS (port i in slice i), source streams.
- REQ-006 SHALL have port s_tready, output, NR_PORTS, per-source ready.
- REQ-007 SHALL have ports m_tdata / m_tkeep / m_tuser / m_tlast / m_tvalid, outputs, merged stream toward to_net.
- REQ-008 SHALL have port m_tready, input, 1, sink ready.
- REQ-009 SHALL have port grant_id, output, clog2(NR_PORTS), currently or last granted port.
- REQ-010 SHALL have port busy, output, 1, high while a packet is locked.
- REQ-011 SHALL have port pkt_cnt, output, 32, count of packets whose tlast beat was accepted on m_*; wraps 0xFFFFFFFF->0.

Function
- REQ-012 SHALL implement FSM with states IDLE and LOCKED.
- REQ-013 In IDLE, any s_tvalid high SHALL select a grant by round-robin starting at rr_ptr, latch grant_id, go LOCKED next cycle; all s_tready are 0 in IDLE.
- REQ-014 In LOCKED, s_tready[grant_id] SHALL equal (!m_tvalid | m_tready); all other s_tready are 0.
- REQ-015 An accepted input beat SHALL appear on m_* exactly 1 cycle later (registered output stage); tdata/tkeep/tuser/tlast pass unmodified.
- REQ-016 m_* SHALL hold stable while m_tvalid=1 and m_tready=0 (AXI-Stream rule); m_tvalid drops after acceptance when no new beat is loaded.
- REQ-017 On acceptance of an input beat with s_tlast=1, FSM SHALL return to IDLE and rr_ptr SHALL become (grant_id+1) mod NR_PORTS.
- REQ-018 Packets SHALL never interleave on m_*: all beats of one packet come from one port, contiguously.
- REQ-019 Between packets SHALL be exactly one IDLE arbitration cycle (no input accepted), independent of m_tready.
- REQ-020 Simultaneous requests SHALL resolve to the first requesting port at or after rr_ptr, cyclically.
- REQ-021 A source deasserting s_tvalid mid-packet SHALL keep the lock (no grant change) until its tlast beat is accepted.
- REQ-022 pkt_cnt SHALL increment on the cycle m_tvalid & m_tready & m_tlast.
- REQ-023 busy SHALL be 1 exactly in LOCKED.

Reset
- REQ-024 sys_rst SHALL asynchronously force: FSM=IDLE, rr_ptr=0, grant_id=0, busy=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata/m_tkeep/m_tuser=0, pkt_cnt=0.
- REQ-025 Reset asserted mid-packet SHALL discard the in-flight beat and lock; the partial packet is not completed after release.
- REQ-026 After sys_rst deasserts, the first grant SHALL occur no earlier than the next clk_390 edge.

Structure
- REQ-027 Round-robin pick SHALL be a sub-module rr_pick (combinational: req vector, pointer -> one-hot grant, valid).
- REQ-028 Shared package kvs_pkg SHALL hold AXIS_DATA_W=64, AXIS_USER_W=64, and FSM state encoding constants.
- REQ-029 Output register SHALL be a single-entry stage inside kvs_tx_arbiter; no FIFOs.

Verification
- REQ-030 Single port 0, 3-beat packet (tdata 0x11,0x22,0x33), m_tready=1 -> grant cycle, m_* shows 0x11,0x22,0x33 on 3 consecutive cycles, tlast on 0x33, pkt_cnt=1.
- REQ-031 Ports 0 and 1 both valid with 2-beat packets at rr_ptr=0 -> port 0 packet fully first, one IDLE cycle, then port 1; rr_ptr ends at 0.
- REQ-032 m_tready toggled 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, m_* stable during stalls, output order preserved.
- REQ-033 Port 1 drops s_tvalid for 5 cycles mid-packet while port 0 valid -> port 0 s_tready stays 0, lock held, port 1 resumes to tlast.
- REQ-034 sys_rst asserted on beat 2 of a 4-beat packet -> next cycle all outputs at reset values, pkt_cnt=0; new packet after release forwarded normally.
- REQ-035 pkt_cnt preset by force to 0xFFFFFFFF, one packet -> pkt_cnt=0.
